// File: rtl/rib_sram_bridge_if.sv
// Bus bundle between the RIB slave-7 port and the external half-word SRAM pads.
// The master side drives the request and the pad read data; the slave side is the bridge.
interface rib_sram_bridge_if #(
    parameter int ADDR_W = 20
);
    logic              req_i;
    logic [31:0]       addr_i;
    logic              we_i;
    logic [31:0]       data_i;
    logic [31:0]       data_o;
    logic              ack_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [15:0]       sram_dq_o;
    logic [15:0]       sram_dq_i;
    logic              sram_dq_oe_o;
    logic              sram_ce_n_o;
    logic              sram_oe_n_o;
    logic              sram_we_n_o;

    modport slave (
        input  req_i, addr_i, we_i, data_i, sram_dq_i,
        output data_o, ack_o, sram_addr_o, sram_dq_o, sram_dq_oe_o,
               sram_ce_n_o, sram_oe_n_o, sram_we_n_o
    );

    modport master (
        output req_i, addr_i, we_i, data_i, sram_dq_i,
        input  data_o, ack_o, sram_addr_o, sram_dq_o, sram_dq_oe_o,
               sram_ce_n_o, sram_oe_n_o, sram_we_n_o
    );
endinterface

// File: rtl/rib_sram_bridge.sv
// RIB slave-7 endpoint: one 32-bit access becomes two 16-bit asynchronous SRAM cycles
// (low half then high half), followed by a one-cycle ack and a deselected turnaround.
module rib_sram_bridge #(
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    rib_sram_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LO, HI, ACK, TURN} state_t;

    // Reads count WAIT_CYC cycles per half; writes add one hold cycle with we_n high.
    localparam logic [3:0] RD_LOAD   = 4'(WAIT_CYC - 1);
    localparam logic [3:0] WR_LOAD   = 4'(WAIT_CYC);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              we_reg;
    logic [ADDR_W-2:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rdata_reg;
    logic              ack_reg;
    logic [ADDR_W-1:0] sram_addr_reg;
    logic [15:0]       dq_reg;
    logic              dq_oe_reg;
    logic              ce_n_reg;
    logic              oe_n_reg;
    logic              we_n_reg;

    // Byte-lane bits and address bits above the SRAM window alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[31:ADDR_W+1], bus.addr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= 32'd0;
            rdata_reg     <= 32'd0;
            ack_reg       <= 1'b0;
            sram_addr_reg <= '0;
            dq_reg        <= 16'd0;
            dq_oe_reg     <= 1'b0;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_i) begin
                        state_reg     <= LO;
                        we_reg        <= bus.we_i;
                        addr_reg      <= bus.addr_i[ADDR_W:2];
                        wdata_reg     <= bus.data_i;
                        cnt_reg       <= bus.we_i ? WR_LOAD : RD_LOAD;
                        sram_addr_reg <= {bus.addr_i[ADDR_W:2], 1'b0};
                        dq_reg        <= bus.data_i[15:0];
                        dq_oe_reg     <= bus.we_i;
                        ce_n_reg      <= 1'b0;
                        oe_n_reg      <= bus.we_i;
                        we_n_reg      <= ~bus.we_i;
                    end
                end
                LO, HI: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                        // Release we_n one cycle before the phase ends so data is held past the strobe.
                        if (we_reg && cnt_reg == 4'd1) begin
                            we_n_reg <= 1'b1;
                        end
                    end else if (state_reg == LO) begin
                        if (!we_reg) begin
                            rdata_reg[15:0] <= bus.sram_dq_i;
                        end
                        state_reg     <= HI;
                        cnt_reg       <= we_reg ? WR_LOAD : RD_LOAD;
                        sram_addr_reg <= {addr_reg, 1'b1};
                        dq_reg        <= wdata_reg[31:16];
                        we_n_reg      <= ~we_reg;
                    end else begin
                        if (!we_reg) begin
                            rdata_reg[31:16] <= bus.sram_dq_i;
                        end
                        state_reg <= ACK;
                        ack_reg   <= 1'b1;
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        we_n_reg  <= 1'b1;
                        dq_oe_reg <= 1'b0;
                    end
                end
                ACK: begin
                    state_reg <= TURN;
                    cnt_reg   <= TURN_LOAD;
                end
                TURN: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.data_o       = rdata_reg;
    assign bus.ack_o        = ack_reg;
    assign bus.sram_addr_o  = sram_addr_reg;
    assign bus.sram_dq_o    = dq_reg;
    assign bus.sram_dq_oe_o = dq_oe_reg;
    assign bus.sram_ce_n_o  = ce_n_reg;
    assign bus.sram_oe_n_o  = oe_n_reg;
    assign bus.sram_we_n_o  = we_n_reg;
endmodule

// File: tb/tb_rib_sram_bridge.sv
// Two bridge instances (2 waits / 1 turn and 1 wait / 3 turns), each on its own SRAM model,
// checked cycle by cycle against a transaction-level reference of the access timing and memory.
module tb_rib_sram_bridge;
    localparam int AW = 20;
    localparam int W0 = 2;
    localparam int T0 = 1;
    localparam int W1 = 1;
    localparam int T1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rib_sram_bridge_if #(.ADDR_W(AW)) bus0 ();
    rib_sram_bridge_if #(.ADDR_W(AW)) bus1 ();

    rib_sram_bridge #(.ADDR_W(AW), .WAIT_CYC(W0), .TURN_CYC(T0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    rib_sram_bridge #(.ADDR_W(AW), .WAIT_CYC(W1), .TURN_CYC(T1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [1:0]    req_v;
    logic [1:0]    we_v;
    logic [31:0]   addr_v  [2];
    logic [31:0]   wdata_v [2];

    assign bus0.req_i  = req_v[0];
    assign bus0.we_i   = we_v[0];
    assign bus0.addr_i = addr_v[0];
    assign bus0.data_i = wdata_v[0];
    assign bus1.req_i  = req_v[1];
    assign bus1.we_i   = we_v[1];
    assign bus1.addr_i = addr_v[1];
    assign bus1.data_i = wdata_v[1];

    logic [1:0]    ack_v, ce_v, oe_v, wen_v, dqoe_v;
    logic [AW-1:0] saddr_v [2];
    logic [15:0]   dqo_v   [2];
    logic [31:0]   rd_v    [2];

    assign ack_v[0] = bus0.ack_o;        assign ack_v[1] = bus1.ack_o;
    assign ce_v[0]  = bus0.sram_ce_n_o;  assign ce_v[1]  = bus1.sram_ce_n_o;
    assign oe_v[0]  = bus0.sram_oe_n_o;  assign oe_v[1]  = bus1.sram_oe_n_o;
    assign wen_v[0] = bus0.sram_we_n_o;  assign wen_v[1] = bus1.sram_we_n_o;
    assign dqoe_v[0] = bus0.sram_dq_oe_o; assign dqoe_v[1] = bus1.sram_dq_oe_o;
    assign saddr_v[0] = bus0.sram_addr_o; assign saddr_v[1] = bus1.sram_addr_o;
    assign dqo_v[0] = bus0.sram_dq_o;    assign dqo_v[1] = bus1.sram_dq_o;
    assign rd_v[0]  = bus0.data_o;       assign rd_v[1]  = bus1.data_o;

    function automatic logic [15:0] init_val(input int u, input int i);
        logic [31:0] x;
        if (u == 0 && i == 8) return 16'hBEEF;
        if (u == 0 && i == 9) return 16'hDEAD;
        x = (i * 40503) ^ (u * 21845) ^ 32'h3C5A;
        return x[15:0];
    endfunction

    // Asynchronous SRAM models: read data while selected and output-enabled, latch on we_n rise.
    logic [15:0] mem0 [2048];
    logic [15:0] mem1 [2048];
    assign bus0.sram_dq_i = (!bus0.sram_ce_n_o && !bus0.sram_oe_n_o) ? mem0[bus0.sram_addr_o[10:0]] : 16'hA5A5;
    assign bus1.sram_dq_i = (!bus1.sram_ce_n_o && !bus1.sram_oe_n_o) ? mem1[bus1.sram_addr_o[10:0]] : 16'hA5A5;

    initial begin
        for (int i = 0; i < 2048; i++) mem0[i] = init_val(0, i);
        forever begin
            @(posedge bus0.sram_we_n_o);
            if (!bus0.sram_ce_n_o && bus0.sram_dq_oe_o) mem0[bus0.sram_addr_o[10:0]] = bus0.sram_dq_o;
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem1[i] = init_val(1, i);
        forever begin
            @(posedge bus1.sram_we_n_o);
            if (!bus1.sram_ce_n_o && bus1.sram_dq_oe_o) mem1[bus1.sram_addr_o[10:0]] = bus1.sram_dq_o;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [15:0] ref_mem [2][2048];
    logic [31:0] exp_rd  [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wcyc(input int u);
        return (u == 0) ? W0 : W1;
    endfunction

    function automatic int tcyc(input int u);
        return (u == 0) ? T0 : T1;
    endfunction

    // {ack, ce_n, oe_n, we_n, dq_oe, sram_addr}
    function automatic logic [24:0] obs(input int u);
        return {ack_v[u], ce_v[u], oe_v[u], wen_v[u], dqoe_v[u], saddr_v[u]};
    endfunction

    task automatic check_idle(input int u, input string tag);
        logic [24:0] ov;
        ov = obs(u);
        chk({tag, "_strb"}, 64'(ov[24:20]), 64'(5'b01110));
        chk({tag, "_rd"}, 64'(rd_v[u]), 64'(exp_rd[u]));
    endtask

    // One access, starting at a negedge with the DUT idle (or about to re-accept a held req).
    // drop_at: sample index after which req is released (-1 keeps it high for a chained access).
    task automatic access(input int u, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int drop_at, input int gap);
        int w, t, plen, lat, base, ph, pj;
        logic [24:0] ov, ev;
        logic [31:0] exp_d;
        w    = wcyc(u);
        t    = tcyc(u);
        plen = wr ? w + 1 : w;
        lat  = 2 * plen;
        base = int'(((a >> 2) & 32'h7FFFF) << 1);
        if (wr) begin
            ref_mem[u][base]     = d[15:0];
            ref_mem[u][base + 1] = d[31:16];
        end else begin
            exp_rd[u] = {ref_mem[u][base + 1], ref_mem[u][base]};
        end
        exp_d = exp_rd[u];
        $display("txn u=%0d %s addr=%08h data=%08h", u, wr ? "wr" : "rd", a, wr ? d : exp_d);
        req_v[u]   = 1'b1;
        we_v[u]    = wr;
        addr_v[u]  = a;
        wdata_v[u] = d;
        for (int j = 0; j <= lat + t; j++) begin
            @(negedge clk);
            ov = obs(u);
            if (j < lat) begin
                ph = j / plen;
                pj = j % plen;
                ev = {1'b0, 1'b0, wr, (wr && pj < w) ? 1'b0 : 1'b1, wr, 20'(base + ph)};
                chk($sformatf("u%0d_strobe_j%0d", u, j), 64'(ov), 64'(ev));
                if (wr) chk($sformatf("u%0d_dq_j%0d", u, j), 64'(dqo_v[u]), 64'(ph == 0 ? d[15:0] : d[31:16]));
            end else if (j == lat) begin
                chk($sformatf("u%0d_ack", u), 64'(ov[24:20]), 64'(5'b11110));
                chk($sformatf("u%0d_rdata", u), 64'(rd_v[u]), 64'(exp_d));
            end else begin
                check_idle(u, $sformatf("u%0d_turn_j%0d", u, j));
            end
            if (j == drop_at) begin
                req_v[u]   = 1'b0;
                we_v[u]    = 1'($urandom);
                addr_v[u]  = $urandom;
                wdata_v[u] = $urandom;
            end
        end
        @(negedge clk);
        check_idle(u, $sformatf("u%0d_idle", u));
        if (drop_at >= 0) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle(u, $sformatf("u%0d_gap", u));
            end
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [24:0] ov;
        bit wr, hold;
        int lat;
        req_v = 2'b00;
        we_v  = 2'b00;
        for (int u = 0; u < 2; u++) begin
            addr_v[u]  = 32'd0;
            wdata_v[u] = 32'd0;
            exp_rd[u]  = 32'd0;
            for (int i = 0; i < 2048; i++) ref_mem[u][i] = init_val(u, i);
        end

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            ov = obs(u);
            chk($sformatf("u%0d_rst_state", u), 64'(ov), 64'({5'b01110, 20'h0}));
            chk($sformatf("u%0d_rst_dq", u), 64'(dqo_v[u]), 64'(0));
            chk($sformatf("u%0d_rst_rd", u), 64'(rd_v[u]), 64'(0));
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle(0, "post_rst0");
            check_idle(1, "post_rst1");
        end

        // Directed unit 0: aliased read, write, back-to-back reads, request drop.
        access(0, 1'b0, 32'h7000_0010, 32'h0, 0, 2);
        chk("rd_beef", 64'(rd_v[0]), 64'(32'hDEADBEEF));
        access(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 0, 1);
        chk("sram_lo", 64'(mem0[16]), 64'(16'h5678));
        chk("sram_hi", 64'(mem0[17]), 64'(16'h1234));
        chk("wr_keeps_rd", 64'(rd_v[0]), 64'(32'hDEADBEEF));
        access(0, 1'b0, 32'h0000_0020, 32'h0, -1, 0);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 0, 4);

        // Directed unit 1: single wait state, long turnaround, chained into a write.
        access(1, 1'b0, 32'h0000_0040, 32'h0, -1, 0);
        access(1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 0, 2);
        access(1, 1'b0, 32'h0000_0044, 32'h0, 0, 1);

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 30; n++) begin
                wr   = 1'($urandom);
                a    = {4'h0, 7'($urandom), 10'h0, 9'($urandom), 2'($urandom)};
                d    = $urandom;
                hold = ($urandom_range(0, 3) == 0) && (n < 29);
                lat  = 2 * (wr ? wcyc(u) + 1 : wcyc(u)) + tcyc(u);
                access(u, wr, a, d, hold ? -1 : int'($urandom_range(0, lat)), hold ? 0 : int'($urandom_range(0, 2)));
            end
        end

        // Reset during the high-half write strobe on unit 0.
        $display("txn u=0 wr addr=00000800 data=0badf00d (reset mid-write)");
        req_v[0]   = 1'b1;
        we_v[0]    = 1'b1;
        addr_v[0]  = 32'h0000_0800;
        wdata_v[0] = 32'h0BAD_F00D;
        repeat (W0 + 2) @(negedge clk);
        ov = obs(0);
        chk("pre_rst_hi_we", 64'({ov[22:20], ov[19:0]}), 64'({3'b101, 20'h401}));
        #2 rst = 1'b0;
        #1;
        ov = obs(0);
        chk("async_rst_strb", 64'(ov), 64'({5'b01110, 20'h0}));
        chk("async_rst_rd", 64'(rd_v[0]), 64'(0));
        req_v[0]  = 1'b0;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_idle(0, "after_rst0");
            check_idle(1, "after_rst1");
        end
        access(0, 1'b0, 32'h0000_0020, 32'h0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rib_sram_bridge.md
Name: rib_sram_bridge

Overview:
- Slave-7 endpoint of the RIB bus. Converts one 32-bit RIB access (req/ack handshake on slave port 7) into two sequential 16-bit cycles on an external asynchronous SRAM.
- Inserts a programmable number of wait states per half-word and a bus turnaround after each access.
- Returns read data and a one-cycle ack. The core's memory master stays stalled until that ack arrives.

Parameters:
- ADDR_W, 20, external half-word address width.
- WAIT_CYC, 2, access cycles per half-word. Legal values are 1 to 15.
- TURN_CYC, 1, idle cycles after each access with chip deselected. Legal values are 1 to 15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req_i  in  1  access request from the bus (slave-7 req)
- addr_i  in  32  byte address within the slave; bits [31:28] are already zero
- we_i  in  1  1 = write, 0 = read
- data_i  in  32  write data
- data_o  out  32  read data
- ack_o  out  1  access complete, one-cycle pulse
- sram_addr_o  out  ADDR_W  half-word address
- sram_dq_o  out  16  write data to the pad
- sram_dq_i  in  16  read data from the pad
- sram_dq_oe_o  out  1  pad output enable
- sram_ce_n_o  out  1  chip enable, active low
- sram_oe_n_o  out  1  output enable, active low
- sram_we_n_o  out  1  write enable, active low

Behaviour:
- Reset (async, rst=0):
  - state = IDLE; counter = 0; data_o = 0; ack_o = 0; sram_addr_o = 0; sram_dq_o = 0; sram_dq_oe_o = 0.
  - ce_n, oe_n and we_n are all 1.
  - Strobes deassert immediately, even mid-write.
- All outputs are registered, with no combinational path from inputs to outputs.
- FSM states: IDLE, LO, HI, ACK, TURN.
- IDLE:
  - req_i is sampled only in IDLE.
  - On req_i=1, latch addr_i, we_i and data_i, then go to LO.
  - req_i changes after acceptance are ignored; the access always completes and always acks.
- Half-word addressing: LO uses {addr_i[ADDR_W:2], 1'b0}; HI uses {addr_i[ADDR_W:2], 1'b1}. Bits addr_i[1:0] and addr_i above ADDR_W are ignored (aliasing).
- Read phase (LO or HI), length WAIT_CYC cycles:
  - ce_n=0, oe_n=0, we_n=1, dq_oe=0.
  - On the last cycle's edge, capture sram_dq_i: LO fills data_o[15:0], HI fills data_o[31:16].
- Write phase (LO or HI), length WAIT_CYC+1 cycles:
  - ce_n=0, oe_n=1, dq_oe=1.
  - sram_dq_o carries data[15:0] in LO and data[31:16] in HI.
  - we_n=0 for the first WAIT_CYC cycles and 1 on the final hold cycle; address and data stay stable throughout.
  - data_o is unchanged by writes.
- Between LO and HI, ce_n stays 0 and the address changes on the phase boundary.
- ACK:
  - Lasts one cycle with ack_o=1, ce_n=1 and dq_oe=0.
  - data_o is final for reads. Between acks, data_o holds the last read value.
- TURN: TURN_CYC cycles with all strobes inactive, then go to IDLE. A req_i held high is re-accepted in IDLE on the next edge.
- Latency, with acceptance edge k:
  - Read: ack_o high from edge k+2*WAIT_CYC to edge k+2*WAIT_CYC+1.
  - Write: ack_o high from edge k+2*(WAIT_CYC+1).
- Back-to-back throughput: one access every 2*WAIT_CYC+1+TURN_CYC+1 cycles for reads, and every 2*WAIT_CYC+3+TURN_CYC+1 cycles for writes.
- Wait counter: 4 bits, reloaded at each phase start, no wrap beyond the phase length.
- After reset release, nothing is accepted until the first edge with rst=1 sees req_i=1 in IDLE.

Test Plan:
- Read, WAIT_CYC=2, TURN_CYC=1:
  - Stimulus: addr_i=0x7000_0010, SRAM model returns 0xBEEF at half-word 0x8 and 0xDEAD at 0x9.
  - Required: ack_o pulses at k+4 with data_o=0xDEADBEEF.
  - Required: sram_addr_o=0x8 for 2 cycles, then 0x9 for 2 cycles; oe_n low for 4 cycles.
- Write, WAIT_CYC=2:
  - Stimulus: data_i=0x12345678, addr_i=0x0000_0020.
  - Required: half-word 0x10 gets 0x5678 and 0x11 gets 0x1234.
  - Required: we_n low for 2 of the 3 cycles in each phase; ack at k+6; data_o unchanged.
- Back-to-back: req_i held high across two reads -> second acceptance exactly TURN_CYC+1 cycles after the first ack, and ce_n high during TURN.
- Request drop: req_i deasserted 1 cycle after acceptance -> access still completes, one ack, and no second access.
- Reset mid-write: rst=0 during HI with we_n low -> we_n, ce_n=1 and dq_oe=0 immediately (asynchronously), data_o=0, ack_o never pulses.
- WAIT_CYC=1, TURN_CYC=3: read -> ack at k+2; next access no earlier than 4 cycles after the ack.
